// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one cmd into a full AW/W->B or AR->R
// transaction and returns the captured response on the rsp port.
module axi_lite_master_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_AW_W | AW and W channels outstanding, each cleared by its own handshake
  // WR_B    | BREADY held high until BVALID
  // RD_AR   | ARVALID held until ARREADY
  // RD_R    | RREADY held high until RVALID
  // RSP     | response presented until rsp_ready
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    BREADY      = 1'b0;
    RREADY      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W may complete in either order or together
        if (AWREADY) awvalid_d = 1'b0;
        if (WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_B;
      end
      WR_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = BRESP;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        RREADY = 1'b1;
        if (RVALID) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          state_d     = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign AWVALID   = awvalid_q;
  assign WVALID    = wvalid_q;
  assign ARVALID   = arvalid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Scoreboarded bench for axi_lite_master_ctrl with a 4-word AXI-Lite slave model
// whose READY delays and RRESP are programmable per test.
module tb_axi_lite_master_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic [31:0] WDATA;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
  logic        BVALID = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = '0;

  axi_lite_master_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model (reacts on the falling edge) ----------------
  int          aw_dly = 1, w_dly = 1;
  logic [1:0]  rresp_cfg = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic        got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  logic [3:0]  s_awaddr = '0, s_araddr = '0;
  logic [31:0] s_wdata = '0;
  logic [31:0] mem [4] = '{default: 32'h0};

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; BVALID = 1'b0; RVALID = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
    end else begin
      BVALID = 1'b0;
      RVALID = 1'b0;
      if (AWREADY) begin AWREADY = 1'b0; aw_cnt = 0; end
      else if (AWVALID) begin
        if (aw_cnt == aw_dly) begin
          AWREADY = 1'b1; s_awaddr = AWADDR; got_aw = 1'b1; aw_hs++;
        end else aw_cnt++;
      end
      if (WREADY) begin WREADY = 1'b0; w_cnt = 0; end
      else if (WVALID) begin
        if (w_cnt == w_dly) begin
          WREADY = 1'b1; s_wdata = WDATA; got_w = 1'b1; w_hs++;
        end else w_cnt++;
      end
      if (ARREADY) begin ARREADY = 1'b0; ar_cnt = 0; end
      else if (ARVALID) begin
        if (ar_cnt == 1) begin
          ARREADY = 1'b1; s_araddr = ARADDR; got_ar = 1'b1; ar_hs++;
        end else ar_cnt++;
      end
      // one-cycle response pulses, one cycle after the last address/data handshake
      if (got_aw && got_w && !AWREADY && !WREADY) begin
        mem[s_awaddr[3:2]] = s_wdata;
        BVALID = 1'b1; BRESP = 2'b00;
        got_aw = 1'b0; got_w = 1'b0;
        if (BREADY) b_hs++;
      end
      if (got_ar && !ARREADY) begin
        RVALID = 1'b1; RDATA = mem[s_araddr[3:2]]; RRESP = rresp_cfg;
        got_ar = 1'b0;
        if (RREADY) r_hs++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    time         acc;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge ACLK) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%08h, required no response", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_write", rsp_write, e.w);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        if (e.lat >= 0) chk("rsp_latency", 32'(($time - e.acc) / 10), e.lat);
      end
    end
  end

  // ---------------- AXI stability monitor ----------------
  logic mon_en = 1'b0, prev_rst = 1'b0;
  logic p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
  logic [3:0]  p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0;

  always @(posedge ACLK) begin
    #2;
    if (mon_en && prev_rst) begin
      if (p_awv) begin
        if (AWREADY) chk("awvalid_drop", AWVALID, 1'b0);
        else begin chk("awvalid_hold", AWVALID, 1'b1); chk("awaddr_stable", AWADDR, p_awaddr); end
      end
      if (p_wv) begin
        if (WREADY) chk("wvalid_drop", WVALID, 1'b0);
        else begin chk("wvalid_hold", WVALID, 1'b1); chk("wdata_stable", WDATA, p_wdata); end
      end
      if (p_arv) begin
        if (ARREADY) chk("arvalid_drop", ARVALID, 1'b0);
        else begin chk("arvalid_hold", ARVALID, 1'b1); chk("araddr_stable", ARADDR, p_araddr); end
      end
    end
    p_awv = AWVALID; p_wv = WVALID; p_arv = ARVALID;
    p_awaddr = AWADDR; p_wdata = WDATA; p_araddr = ARADDR;
    prev_rst = ARESETn;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic [1:0] eresp, input int lat,
                       input bit push, output time acc);
    exp_t e;
    bit   done = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    acc = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin
        @(posedge ACLK);
        acc = $time;
        if (push) begin
          e.w = w; e.rdata = er; e.resp = eresp; e.lat = lat; e.acc = acc;
          exp_q.push_back(e);
        end
        #1 cmd_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL cmd_accept_timeout: got cmd_ready low for 60 cycles, required acceptance");
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ACLK);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL rsp_timeout: got %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    time t0, t1;
    int  aw0, w0, b0, ar0, r0;
    bit  seen;

    // reset state
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_bready", BREADY, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", rsp_resp, 2'b00);
    chk("rst_awaddr", AWADDR, 4'h0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    mon_en  = 1'b1;
    @(posedge ACLK); #1;

    // write then readback, nominal latency and back-to-back spacing
    issue(1'b1, 4'h4, 32'hDEADBEEF, 32'h0, 2'b00, 3, 1, t0);
    issue(1'b0, 4'h4, 32'h0, 32'hDEADBEEF, 2'b00, 3, 1, t1);
    chk("cmd_spacing", 32'((t1 - t0) / 10), 32'd5);
    drain();

    // full sweep
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    issue(1'b1, 4'h0, 32'h11111111, 32'h0, 2'b00, 3, 1, t0);
    issue(1'b1, 4'h4, 32'h22222222, 32'h0, 2'b00, 3, 1, t0);
    issue(1'b1, 4'h8, 32'h33333333, 32'h0, 2'b00, 3, 1, t0);
    issue(1'b1, 4'hC, 32'h44444444, 32'h0, 2'b00, 3, 1, t0);
    issue(1'b0, 4'h0, 32'h0, 32'h11111111, 2'b00, 3, 1, t0);
    issue(1'b0, 4'h4, 32'h0, 32'h22222222, 2'b00, 3, 1, t0);
    issue(1'b0, 4'h8, 32'h0, 32'h33333333, 2'b00, 3, 1, t0);
    issue(1'b0, 4'hC, 32'h0, 32'h44444444, 2'b00, 3, 1, t0);
    drain();
    chk("sweep_aw_count", aw_hs - aw0, 32'd4);
    chk("sweep_w_count", w_hs - w0, 32'd4);
    chk("sweep_b_count", b_hs - b0, 32'd4);
    chk("sweep_ar_count", ar_hs - ar0, 32'd4);
    chk("sweep_r_count", r_hs - r0, 32'd4);

    // response back-pressure on a read of 0x8
    rsp_ready = 1'b0;
    ar0 = ar_hs;
    issue(1'b0, 4'h8, 32'h0, 32'h33333333, 2'b00, -1, 1, t0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (rsp_valid) seen = 1;
    end
    chk("bp_rsp_arrived", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
      @(negedge ACLK);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h33333333);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_arvalid", ARVALID, 1'b0);
    end
    chk("bp_ar_count", ar_hs - ar0, 32'd1);
    @(posedge ACLK); #1;
    rsp_ready = 1'b1;
    issue(1'b0, 4'h0, 32'h0, 32'h11111111, 2'b00, -1, 1, t0);
    drain();

    // split handshakes: W lags AW by 3 cycles
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    w_dly = 4;
    issue(1'b1, 4'h0, 32'hA5A5A5A5, 32'h0, 2'b00, 6, 1, t0);
    drain();
    w_dly = 1;
    chk("split_aw_count", aw_hs - aw0, 32'd1);
    chk("split_w_count", w_hs - w0, 32'd1);
    chk("split_b_count", b_hs - b0, 32'd1);
    issue(1'b0, 4'h0, 32'h0, 32'hA5A5A5A5, 2'b00, 3, 1, t0);
    drain();

    // error passthrough
    rresp_cfg = 2'b10;
    issue(1'b0, 4'hC, 32'h0, 32'h44444444, 2'b10, 3, 1, t0);
    drain();
    rresp_cfg = 2'b00;

    // reset in the middle of a write
    aw_dly = 10; w_dly = 10;
    b0 = b_hs;
    issue(1'b1, 4'h4, 32'h00000BAD, 32'h0, 2'b00, -1, 0, t0);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("mrst_awvalid", AWVALID, 1'b0);
    chk("mrst_wvalid", WVALID, 1'b0);
    chk("mrst_cmd_ready", cmd_ready, 1'b1);
    chk("mrst_rsp_valid", rsp_valid, 1'b0);
    aw_dly = 1; w_dly = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("mrst_no_rsp", rsp_valid, 1'b0);
    end
    chk("mrst_b_count", b_hs - b0, 32'd0);
    @(posedge ACLK); #1;
    issue(1'b0, 4'h4, 32'h0, 32'h22222222, 2'b00, 3, 1, t0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_lite_master_ctrl.md
# axi_lite_master_ctrl

- Single-outstanding AXI4-Lite master controller.
- Converts a simple command/response port into complete AXI-Lite write (AW+W → B) and read (AR → R) transactions.
- Sits between a local sequencer (CPU stub, UART bridge, test FSM) and the 4-register AXI-Lite slave bank, and is the only master driving that bank.
- Commands are serialized: one transaction at a time, in acceptance order.

## Interface
Parameters:
- ADDR_W, 4, AXI address width (byte address)
- DATA_W, 32, data width

Ports:
- ACLK  input  1  clock, all logic on rising edge
- ARESETn  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  target byte address
- cmd_wdata  input  DATA_W  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_write  output  1  response belongs to a write
- rsp_rdata  output  DATA_W  captured RDATA (0 for writes)
- rsp_resp  output  2  captured BRESP/RRESP
- AWADDR  output  ADDR_W  write address
- AWVALID  output  1
- AWREADY  input  1
- WDATA  output  DATA_W
- WVALID  output  1
- WREADY  input  1
- BRESP  input  2
- BVALID  input  1
- BREADY  output  1
- ARADDR  output  ADDR_W
- ARVALID  output  1
- ARREADY  input  1
- RDATA  input  DATA_W
- RVALID  input  1
- RREADY  output  1
- RRESP  input  2

## Operation
States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.

- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: latch cmd_addr/cmd_wdata/cmd_write.
  - Write → WR_AW_W with AWVALID=WVALID=1. Read → RD_AR with ARVALID=1.
- **WR_AW_W**
  - AWVALID and WVALID are registered and tracked independently.
  - Each clears on the edge its own VALID&READY is sampled, so the low level is seen the very next cycle.
  - Exit to WR_B when both handshakes are done, whether they occurred the same cycle or different cycles.
- **WR_B**
  - BREADY=1 for the whole state, so a slave that pulses BVALID for one cycle is never missed.
  - On BVALID: capture BRESP, set rsp_write=1, rsp_rdata=0, go to RSP.
- **RD_AR**
  - ARVALID held until ARVALID&ARREADY; cleared on that edge; go to RD_R.
- **RD_R**
  - RREADY=1 for the whole state.
  - On RVALID: capture RDATA/RRESP, set rsp_write=0, go to RSP.
- **RSP**
  - rsp_valid=1; rsp fields stable until rsp_valid&rsp_ready, then go to IDLE.
  - cmd_ready=0 until back in IDLE.

General rules:
- AWADDR/WDATA/ARADDR are driven from the latched registers and stay stable while their VALID is high.
- VALIDs never drop before their handshake.
- Non-zero BRESP/RRESP is forwarded unchanged; no retry.
- Unexpected BVALID/RVALID outside WR_B/RD_R is ignored; BREADY/RREADY=0 there.

## Timing
- Reset values: all VALID/READY outputs 0, rsp_* 0, address/data regs 0; state IDLE, so cmd_ready=1 during and after reset.
- Reset mid-transaction: return to IDLE next edge and drop all VALIDs; the in-flight transaction is discarded with no response.
- Slave timing for the figures below: READY 1 cycle after VALID, BVALID/RVALID 1 cycle after W/AR handshake.
- Write, with command accepted at edge 0:
  - AWVALID/WVALID high in cycle 1.
  - AW and W handshakes at edge 2.
  - BVALID/BREADY at edge 3.
  - rsp_valid in cycle 4.
- Read: AR handshake at edge 2, R at edge 3, rsp_valid in cycle 4.
- rsp_ready already high at entry → RSP lasts 1 cycle, so the next command can be accepted 5 cycles after the previous one.
- Back-pressure on rsp_ready stalls indefinitely with no AXI activity.

## Test plan
- **Write then readback:** write 0x4 = 0xDEADBEEF, then read 0x4 → write rsp resp=00 at cycle 4; read rsp rdata=0xDEADBEEF, resp=00.
- **Full sweep:** write 0x0/0x4/0x8/0xC = 0x11111111..0x44444444, read all back → exact match, one AW, one W and one B handshake per write.
- **Split handshakes:** slave delays WREADY 3 cycles after AWREADY → AWVALID drops after its handshake, WVALID held with WDATA stable, one BREADY/BVALID, a single response.
- **Response back-pressure:** rsp_ready=0 for 5 cycles after a read of 0x8 → rsp_valid and rsp_rdata held constant, cmd_ready=0, no new ARVALID until rsp_ready=1.
- **Error passthrough:** slave returns RRESP=10 → rsp_resp=10 with rdata captured.
- **Reset mid-write:** assert ARESETn=0 in WR_AW_W → next cycle AWVALID=WVALID=0, cmd_ready=1, no rsp_valid.
